// File: rtl/matvec_pkg.sv
// Shared types and sizing for the matrix/vector fetch path in front of mat_vec_mult.
package matvec_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int DEPTH      = 8;
    localparam int LINE_W     = DATA_WIDTH * DEPTH;

    typedef logic [LINE_W-1:0] line_t;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        REQ,
        DRAIN,
        BSER,
        DONE
    } state_t;

endpackage

// File: rtl/line_serializer.sv
// Holds one memory line and plays it out one element per cycle, LSB element first.
module line_serializer
    import matvec_pkg::*;
(
    input  logic                  CLOCK_50,
    input  logic                  rst_n,
    input  logic                  load,
    input  line_t                 line,
    input  logic                  go,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  last
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    line_t            shreg;
    logic [IDX_W-1:0] idx;
    logic             active;

    // Loading and emitting are separate so the line can be captured well before playback.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            shreg  <= '0;
            idx    <= '0;
            active <= 1'b0;
        end else begin
            if (load) begin
                shreg <= line;
            end
            if (go) begin
                active <= 1'b1;
                idx    <= '0;
            end else if (active) begin
                shreg <= shreg >> DATA_WIDTH;
                idx   <= idx + IDX_W'(1);
                if (idx == IDX_W'(DEPTH - 1)) begin
                    active <= 1'b0;
                end
            end
        end
    end

    assign valid = active;
    assign data  = active ? shreg[DATA_WIDTH-1:0] : '0;
    assign last  = active && (idx == IDX_W'(DEPTH - 1));

endmodule

// File: rtl/matvec_loader.sv
// Fetches DEPTH matrix rows plus one vector line over Avalon-MM and feeds the A/B FIFOs.
module matvec_loader
    import matvec_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
)
(
    input  logic                  CLOCK_50,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [31:0]           base_addr,
    output logic [31:0]           address,
    output logic                  read,
    input  logic [LINE_W-1:0]     readdata,
    input  logic                  readdatavalid,
    input  logic                  waitrequest,
    output logic                  clr,
    output logic                  a_wren,
    output logic [LINE_W-1:0]     a_row,
    output logic                  b_wren,
    output logic [DATA_WIDTH-1:0] b_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int CNT_W = $clog2(DEPTH + 2);
    localparam int OUT_W = 4;

    state_t           state;
    logic [31:0]      base;
    logic [CNT_W-1:0] req_cnt;
    logic [CNT_W-1:0] resp_cnt;
    logic [OUT_W-1:0] outstanding;

    logic                  accept;
    logic                  beat;
    logic                  b_capture;
    logic                  ser_go;
    logic                  ser_valid;
    logic                  ser_last;
    logic [DATA_WIDTH-1:0] ser_data;

    // read depends only on registered state, so it cannot drop while the slave stalls.
    assign read    = (state == REQ) && (req_cnt <= CNT_W'(DEPTH))
                     && (outstanding < OUT_W'(MAX_OUTSTANDING));
    assign address = read ? base + 32'(req_cnt) : '0;
    assign accept  = read && !waitrequest;

    assign beat      = readdatavalid && ((state == REQ) || (state == DRAIN))
                       && (outstanding != '0);
    assign a_wren    = beat && (resp_cnt < CNT_W'(DEPTH));
    assign a_row     = a_wren ? readdata : '0;
    assign b_capture = beat && (resp_cnt == CNT_W'(DEPTH));
    assign ser_go    = (state == DRAIN) && (resp_cnt == CNT_W'(DEPTH + 1))
                       && (outstanding == '0);

    assign clr    = (state == CLR);
    assign busy   = (state != IDLE) && (state != DONE);
    assign done   = (state == DONE);
    assign b_wren = ser_valid;
    assign b_data = ser_data;

    // Counters update before the state case so an accepted start's clear takes priority.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            base        <= '0;
            req_cnt     <= '0;
            resp_cnt    <= '0;
            outstanding <= '0;
            err         <= 1'b0;
        end else begin
            if (readdatavalid && !beat) begin
                err <= 1'b1;
            end
            if (accept) begin
                req_cnt <= req_cnt + CNT_W'(1);
            end
            if (beat) begin
                resp_cnt <= resp_cnt + CNT_W'(1);
            end
            case ({accept, beat})
                2'b10:   outstanding <= outstanding + OUT_W'(1);
                2'b01:   outstanding <= outstanding - OUT_W'(1);
                default: outstanding <= outstanding;
            endcase

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        base        <= base_addr;
                        err         <= 1'b0;
                        req_cnt     <= '0;
                        resp_cnt    <= '0;
                        outstanding <= '0;
                        state       <= CLR;
                    end
                end
                CLR: begin
                    state <= REQ;
                end
                REQ: begin
                    if (accept && (req_cnt == CNT_W'(DEPTH))) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (ser_go) begin
                        state <= BSER;
                    end
                end
                BSER: begin
                    if (ser_last) begin
                        state <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    line_serializer u_ser (
        .CLOCK_50 (CLOCK_50),
        .rst_n    (rst_n),
        .load     (b_capture),
        .line     (readdata),
        .go       (ser_go),
        .valid    (ser_valid),
        .data     (ser_data),
        .last     (ser_last)
    );

endmodule

// File: tb/tb_matvec_loader.sv
// Scoreboard bench for matvec_loader: behavioural memory, expected queues and a negedge monitor.
module tb_matvec_loader;
    import matvec_pkg::*;

    localparam int MAXO = 4;

    logic                  CLOCK_50 = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  start = 1'b0;
    logic [31:0]           base_addr = '0;
    logic [31:0]           address;
    logic                  read;
    logic [LINE_W-1:0]     readdata = '0;
    logic                  readdatavalid = 1'b0;
    logic                  waitrequest = 1'b0;
    logic                  clr;
    logic                  a_wren;
    logic [LINE_W-1:0]     a_row;
    logic                  b_wren;
    logic [DATA_WIDTH-1:0] b_data;
    logic                  busy;
    logic                  done;
    logic                  err;

    always #5 CLOCK_50 = ~CLOCK_50;

    matvec_loader #(.MAX_OUTSTANDING(MAXO)) dut (
        .CLOCK_50      (CLOCK_50),
        .rst_n         (rst_n),
        .start         (start),
        .base_addr     (base_addr),
        .address       (address),
        .read          (read),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .waitrequest   (waitrequest),
        .clr           (clr),
        .a_wren        (a_wren),
        .a_row         (a_row),
        .b_wren        (b_wren),
        .b_data        (b_data),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    typedef struct {
        line_t  data;
        longint due;
    } resp_t;

    int          checks = 0;
    int          failures = 0;
    int          latency = 2;
    int          wr_prob = 0;
    bit          pattern_mode = 1'b1;
    logic [31:0] seed = '0;
    bit          hold_armed = 1'b0;
    logic [31:0] hold_addr = '0;
    int          hold_left = 0;
    longint      cyc = 0;
    int          accepts = 0;
    int          delivered = 0;
    int          out_tb = 0;
    int          clr_count = 0;
    bit          saw_full = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_addr = '0;

    logic [31:0] exp_addr[$];
    line_t       exp_a[$];
    logic [7:0]  exp_b[$];
    resp_t       pend[$];

    function automatic line_t mem_line(input logic [31:0] a);
        if (pattern_mode) return {8{a[7:0]}};
        return {a ^ seed, (~a) + seed};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic flagFail(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s actual=unexpected expected=none", name);
    endtask

    // Memory slave plus monitor: drives this cycle's inputs, then samples DUT outputs 1ns later.
    initial begin
        line_t l;
        forever begin
            @(negedge CLOCK_50);
            cyc++;
            out_tb = accepts - delivered;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                readdata      = pend[0].data;
                readdatavalid = 1'b1;
                void'(pend.pop_front());
                delivered++;
            end else begin
                readdata      = '0;
                readdatavalid = 1'b0;
            end
            if (hold_left > 0) begin
                waitrequest = 1'b1;
                hold_left--;
            end else if (hold_armed && read && address == hold_addr) begin
                hold_armed  = 1'b0;
                waitrequest = 1'b1;
                hold_left   = 2;
            end else begin
                waitrequest = ($urandom_range(99) < wr_prob);
            end
            #1;
            if (rst_n) begin
                if (prev_stall) begin
                    checkOutput("hold_read", 64'(read), 64'd1);
                    checkOutput("hold_addr", 64'(address), 64'(prev_addr));
                end
                if (read) begin
                    checkOutput("outstanding_limit", 64'(out_tb < MAXO), 64'd1);
                end
                if (out_tb >= MAXO) saw_full = 1'b1;
                if (read && !waitrequest) begin
                    if (exp_addr.size() == 0) flagFail("extra_read");
                    else checkOutput("address", 64'(address), 64'(exp_addr.pop_front()));
                    l = mem_line(address);
                    pend.push_back('{data: l, due: cyc + latency});
                    accepts++;
                end
                if (a_wren) begin
                    if (exp_a.size() == 0) flagFail("extra_a_wren");
                    else checkOutput("a_row", a_row, exp_a.pop_front());
                end
                if (b_wren) begin
                    if (exp_b.size() == 0) flagFail("extra_b_wren");
                    else checkOutput("b_data", 64'(b_data), 64'(exp_b.pop_front()));
                end
                if (clr) clr_count++;
                prev_stall = read && waitrequest;
                prev_addr  = address;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] b, input int lat, input bit pmode, input int wprob);
        line_t bl;
        latency      = lat;
        pattern_mode = pmode;
        seed         = $urandom;
        wr_prob      = wprob;
        exp_addr.delete();
        exp_a.delete();
        exp_b.delete();
        for (int i = 0; i <= DEPTH; i++) exp_addr.push_back(b + 32'(i));
        for (int i = 0; i < DEPTH; i++) exp_a.push_back(mem_line(b + 32'(i)));
        bl = mem_line(b + 32'(DEPTH));
        for (int j = 0; j < DEPTH; j++) exp_b.push_back(bl[8*j +: 8]);
        clr_count = 0;
        accepts   = 0;
        delivered = 0;
        saw_full  = 1'b0;
        start     = 1'b1;
        base_addr = b;
        @(negedge CLOCK_50);
        start     = 1'b0;
        base_addr = $urandom;
    endtask

    task automatic waitDone(input string name);
        for (int i = 0; i < 600; i++) begin
            @(negedge CLOCK_50);
            #2;
            if (done) break;
        end
        checkOutput({name, "_done"}, 64'(done), 64'd1);
        checkOutput({name, "_err"}, 64'(err), 64'd0);
        checkOutput({name, "_busy"}, 64'(busy), 64'd0);
        checkOutput({name, "_clr_pulses"}, 64'(clr_count), 64'd1);
        checkOutput({name, "_rows_left"}, 64'(exp_a.size()), 64'd0);
        checkOutput({name, "_b_left"}, 64'(exp_b.size()), 64'd0);
        checkOutput({name, "_addr_left"}, 64'(exp_addr.size()), 64'd0);
    endtask

    task automatic checkQuiet(input string name);
        checkOutput({name, "_read"}, 64'(read), 64'd0);
        checkOutput({name, "_address"}, 64'(address), 64'd0);
        checkOutput({name, "_clr"}, 64'(clr), 64'd0);
        checkOutput({name, "_a_wren"}, 64'(a_wren), 64'd0);
        checkOutput({name, "_a_row"}, a_row, 64'd0);
        checkOutput({name, "_b_wren"}, 64'(b_wren), 64'd0);
        checkOutput({name, "_b_data"}, 64'(b_data), 64'd0);
        checkOutput({name, "_busy"}, 64'(busy), 64'd0);
        checkOutput({name, "_done"}, 64'(done), 64'd0);
        checkOutput({name, "_err"}, 64'(err), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout actual=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        repeat (3) @(negedge CLOCK_50);
        #2;
        checkQuiet("reset");
        rst_n = 1'b1;
        @(negedge CLOCK_50);

        $display("[TB] test 1: zero-wait, latency 2, patterned lines");
        applyStimulus(32'h0, 2, 1'b1, 0);
        waitDone("t1");

        $display("[TB] test 2: waitrequest held on request 4");
        hold_armed = 1'b1;
        hold_addr  = 32'h4;
        applyStimulus(32'h0, 2, 1'b1, 0);
        waitDone("t2");
        checkOutput("t2_hold_used", 64'(hold_armed), 64'd0);

        $display("[TB] test 3: latency 10, outstanding limit");
        applyStimulus($urandom, 10, 1'b0, 0);
        waitDone("t3");
        checkOutput("t3_limit_reached", 64'(saw_full), 64'd1);

        $display("[TB] test 4: address wrap");
        applyStimulus(32'hFFFF_FFFE, 3, 1'b0, 0);
        waitDone("t4");

        $display("[TB] test 5: start while busy, restart from DONE");
        applyStimulus(32'h100, 4, 1'b0, 20);
        repeat (4) @(negedge CLOCK_50);
        start     = 1'b1;
        base_addr = 32'h5555;
        @(negedge CLOCK_50);
        start     = 1'b0;
        waitDone("t5a");
        applyStimulus(32'h200, 4, 1'b0, 20);
        #2;
        checkOutput("t5_done_cleared", 64'(done), 64'd0);
        checkOutput("t5_busy_rerun", 64'(busy), 64'd1);
        waitDone("t5b");

        $display("[TB] test 6: reset during REQ");
        applyStimulus(32'h40, 6, 1'b0, 0);
        for (int i = 0; i < 100; i++) begin
            #2;
            if (accepts >= 3) break;
            @(negedge CLOCK_50);
        end
        checkOutput("t6_three_accepts", 64'(accepts), 64'd3);
        @(posedge CLOCK_50);
        #1;
        rst_n = 1'b0;
        #1;
        checkQuiet("t6_reset");
        exp_addr.delete();
        exp_a.delete();
        exp_b.delete();
        repeat (2) @(negedge CLOCK_50);
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLOCK_50);
            #2;
            if (pend.size() == 0 && !readdatavalid) break;
        end
        @(negedge CLOCK_50);
        #2;
        checkOutput("t6_stray_err", 64'(err), 64'd1);
        checkOutput("t6_idle_busy", 64'(busy), 64'd0);
        applyStimulus(32'h80, 2, 1'b0, 0);
        #2;
        checkOutput("t6_err_cleared", 64'(err), 64'd0);
        waitDone("t6");

        $display("[TB] randomized loads");
        for (int r = 0; r < 4; r++) begin
            applyStimulus($urandom, $urandom_range(1, 6), 1'b0, 30);
            waitDone("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
